psum_accumulator: RTL

//  Downstream of the output FIFO in the corelet: takes one row of col partial sums per handshake,

---
 rtl/psum_acc_pkg.sv | 21 ++
 rtl/psum_accumulator_sat_add.sv | 13 +
 rtl/psum_accumulator.sv | 91 +++++++++
 3 files changed

// File: rtl/psum_acc_pkg.sv
// psum_acc_pkg: shared widths, lane type and saturating add for the psum accumulator.
package psum_acc_pkg;

    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int DEPTH   = 16;
    localparam int ADDR_BW = 4;

    typedef logic signed [PSUM_BW-1:0] lane_t;

    localparam lane_t PSUM_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam lane_t PSUM_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

    // One guard bit is enough: overflow shows as the top two sum bits disagreeing.
    function automatic lane_t sat(input lane_t a, input lane_t b);
        logic signed [PSUM_BW:0] s;
        s = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
        return (s[PSUM_BW] == s[PSUM_BW-1]) ? s[PSUM_BW-1:0] : (s[PSUM_BW] ? PSUM_MIN : PSUM_MAX);
    endfunction

endpackage

// File: rtl/psum_accumulator_sat_add.sv
// psum_sat_add: one lane of the accumulator update, overwrite on first pass else saturating add.
module psum_sat_add
    import psum_acc_pkg::*;
(
    input  lane_t old,
    input  lane_t psum,
    input  logic  first,
    output lane_t sum
);

    assign sum = first ? psum : sat(old, psum);

endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: two-stage read-modify-write psum buffer with forwarding and a readout port.
// Optional PSUM_ACC_RELU_EN applies ReLU to readout lanes only; stored sums stay signed.
module psum_accumulator
    import psum_acc_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int col     = COL,
    parameter int depth   = DEPTH,
    parameter int addr_bw = ADDR_BW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [col*psum_bw-1:0] i_data,
    input  logic [addr_bw-1:0]     i_addr,
    input  logic                   i_first,
    input  logic                   o_rd,
    input  logic [addr_bw-1:0]     o_addr,
    output logic                   o_valid,
    output logic [col*psum_bw-1:0] o_data,
    output logic                   busy
);

    localparam int rw = col * psum_bw;
    localparam logic [(1<<addr_bw)-1:0] amask = {(1<<addr_bw){1'b1}} >> ((1<<addr_bw) - depth);

    logic [rw-1:0]      mem [depth];
    logic [depth-1:0]   flag;
    logic               s2_valid;
    logic               s2_first;
    logic [addr_bw-1:0] s2_addr;
    logic [rw-1:0]      s2_data;
    logic [rw-1:0]      s2_old;
    logic [rw-1:0]      s2_sum;
    logic [rw-1:0]      rd_in;
    logic [rw-1:0]      rd_out;
    logic [rw-1:0]      o_lanes;
    logic               s2_we;
    logic               acc;

    assign i_ready = ~reset & ~o_rd;
    assign acc     = i_valid & i_ready;
    assign s2_we   = s2_valid & amask[s2_addr];
    assign busy    = s2_valid;

    // Both read ports see the value being written this cycle, so nothing ever reads stale.
    assign rd_in  = (s2_we && s2_addr == i_addr) ? s2_sum :
                    (amask[i_addr] && flag[i_addr]) ? mem[i_addr] : '0;
    assign rd_out = (s2_we && s2_addr == o_addr) ? s2_sum :
                    (amask[o_addr] && flag[o_addr]) ? mem[o_addr] : '0;

    for (genvar k = 0; k < col; k++) begin : g_lane
        psum_sat_add u_add (
            .old   (s2_old[k*psum_bw +: psum_bw]),
            .psum  (s2_data[k*psum_bw +: psum_bw]),
            .first (s2_first),
            .sum   (s2_sum[k*psum_bw +: psum_bw])
        );
`ifdef PSUM_ACC_RELU_EN
        assign o_lanes[k*psum_bw +: psum_bw] = rd_out[k*psum_bw + psum_bw - 1] ? '0 : rd_out[k*psum_bw +: psum_bw];
`else
        assign o_lanes[k*psum_bw +: psum_bw] = rd_out[k*psum_bw +: psum_bw];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            flag     <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
        end else begin
            s2_valid <= acc;
            if (s2_we) flag[s2_addr] <= 1'b1;
            o_valid <= o_rd;
            if (o_rd) o_data <= o_lanes;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            s2_data  <= i_data;
            s2_addr  <= i_addr;
            s2_first <= i_first;
            s2_old   <= rd_in;
        end
        if (s2_we) mem[s2_addr] <= s2_sum;
    end

endmodule
